// File: rtl/sser_tx.sv
// SSER bus-window serial transmitter: CPU writes a byte, block shifts it out
// as start / 8 data (LSB first) / optional parity / stop on sdwr.
module sser_tx #(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sser_n,
  input  logic       ba13,
  input  logic       ba12,
  input  logic [3:0] ba,
  input  logic       br_w,
  input  logic [7:0] bd_in,
  output logic [7:0] bd_out,
  output logic       bd_oe,
  output logic       sdwr,
  output logic       tx_busy,
  output logic       irq
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  // state | meaning
  // IDLE  | line at 1, waiting for a full holding register
  // START | start bit (0)
  // DATA  | eight data bits, LSB first
  // PAR   | parity bit, only when the frame latched par_en
  // STOP  | stop bit (1); reloads straight into START if hold is full
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t          state;
  logic            sel, sel_d, commit;
  logic            wr_data, wr_ctrl, rd_status;
  logic [7:0]      hold, shift;
  logic            hold_empty, overrun;
  logic            par_en, par_odd, irq_en;
  logic            f_par_en, f_par_bit;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic            bit_end, load, accept;
  logic            hold_empty_nx, irq_en_nx;

  assign sel       = ~sser_n & ~ba13 & ba12;
  assign commit    = sel & ~sel_d;
  assign wr_data   = commit & ~br_w & (ba == 4'h2);
  assign wr_ctrl   = commit & ~br_w & (ba == 4'h3);
  assign rd_status = commit & br_w & (ba == 4'h0);

  assign bit_end = (baud_cnt == CNT_LAST);
  assign load    = ~hold_empty & ((state == IDLE) | ((state == STOP) & bit_end));
  // The transfer empties hold in the same cycle, so a coincident write fits.
  assign accept  = wr_data & (hold_empty | load);

  assign hold_empty_nx = wr_data ? 1'b0 : (load ? 1'b1 : hold_empty);
  assign irq_en_nx     = wr_ctrl ? bd_in[2] : irq_en;

  assign tx_busy = (state != IDLE);
  assign bd_oe   = sel & br_w;

  always_comb begin
    bd_out = 8'h00;
    if (bd_oe) begin
      case (ba)
        4'h0:    bd_out = {5'b0, overrun, tx_busy, hold_empty};
        4'h3:    bd_out = {5'b0, irq_en, par_odd, par_en};
        default: bd_out = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel_d      <= 1'b0;
      hold       <= 8'h00;
      shift      <= 8'h00;
      hold_empty <= 1'b1;
      overrun    <= 1'b0;
      par_en     <= 1'b0;
      par_odd    <= 1'b0;
      irq_en     <= 1'b0;
      f_par_en   <= 1'b0;
      f_par_bit  <= 1'b0;
      baud_cnt   <= '0;
      bit_cnt    <= 3'd0;
      sdwr       <= 1'b1;
      irq        <= 1'b0;
    end else begin
      sel_d      <= sel;
      hold_empty <= hold_empty_nx;
      irq        <= irq_en_nx & hold_empty_nx;
      if (accept) hold <= bd_in;
      if (wr_data & ~accept) overrun <= 1'b1;
      else if (rd_status)    overrun <= 1'b0;
      if (wr_ctrl) {irq_en, par_odd, par_en} <= bd_in[2:0];

      if (load) begin
        shift     <= hold;
        f_par_en  <= par_en;
        f_par_bit <= ^hold ^ par_odd;
        state     <= START;
        sdwr      <= 1'b0;
        baud_cnt  <= '0;
        bit_cnt   <= 3'd0;
      end else begin
        case (state)
          IDLE: sdwr <= 1'b1;
          START: begin
            if (bit_end) begin
              baud_cnt <= '0;
              state    <= DATA;
              sdwr     <= shift[0];
            end else baud_cnt <= baud_cnt + CW'(1);
          end
          DATA: begin
            if (bit_end) begin
              baud_cnt <= '0;
              if (bit_cnt == 3'd7) begin
                state <= f_par_en ? PAR : STOP;
                sdwr  <= f_par_en ? f_par_bit : 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
                shift   <= shift >> 1;
                sdwr    <= shift[1];
              end
            end else baud_cnt <= baud_cnt + CW'(1);
          end
          PAR: begin
            if (bit_end) begin
              baud_cnt <= '0;
              state    <= STOP;
              sdwr     <= 1'b1;
            end else baud_cnt <= baud_cnt + CW'(1);
          end
          STOP: begin
            if (bit_end) begin
              baud_cnt <= '0;
              state    <= IDLE;
              sdwr     <= 1'b1;
            end else baud_cnt <= baud_cnt + CW'(1);
          end
          default: begin
            state <= IDLE;
            sdwr  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sser_tx.sv
// Bench for sser_tx: traces sdwr/tx_busy/irq per cycle and compares them with
// frames built from the frame format (start, LSB-first data, parity, stop).
module tb_sser_tx;
  localparam int DIV = 4;
  localparam int TR  = 16384;

  logic       clk = 1'b0;
  logic       rst, sser_n, ba13, ba12, br_w;
  logic [3:0] ba;
  logic [7:0] bd_in, bd_out;
  logic       bd_oe, sdwr, tx_busy, irq;

  sser_tx #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .sser_n(sser_n), .ba13(ba13), .ba12(ba12),
    .ba(ba), .br_w(br_w), .bd_in(bd_in), .bd_out(bd_out), .bd_oe(bd_oe),
    .sdwr(sdwr), .tx_busy(tx_busy), .irq(irq)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  logic last_oe;
  logic sd_tr[TR], bsy_tr[TR], irq_tr[TR];
  logic exp_sd[TR], exp_bsy[TR];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cyc < TR) begin
    sd_tr[cyc]  <= sdwr;
    bsy_tr[cyc] <= tx_busy;
    irq_tr[cyc] <= irq;
  end

  task automatic idle_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [7:0] d, output int n);
    sser_n = 1'b0; ba13 = 1'b0; ba12 = 1'b1; ba = a; br_w = 1'b0; bd_in = d;
    n = cyc;
    @(negedge clk);
    sser_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [7:0] d);
    sser_n = 1'b0; ba13 = 1'b0; ba12 = 1'b1; ba = a; br_w = 1'b1;
    #1;
    d = bd_out;
    last_oe = bd_oe;
    @(negedge clk);
    sser_n = 1'b1; br_w = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_exp(input int a, input int b);
    for (int t = a; t < b; t++) begin
      exp_sd[t]  = 1'b1;
      exp_bsy[t] = 1'b0;
    end
  endtask

  // Expected line image of one frame starting at cycle s; e = first cycle after it.
  task automatic model_frame(input int s, input logic [7:0] b, input bit pe,
                             input bit po, output int e);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (pe) bits.push_back(bit'(($countones(b) + int'(po)) % 2));
    bits.push_back(1'b1);
    for (int i = 0; i < bits.size(); i++)
      for (int j = 0; j < DIV; j++) begin
        exp_sd[s + i*DIV + j]  = bits[i];
        exp_bsy[s + i*DIV + j] = 1'b1;
      end
    e = s + bits.size() * DIV;
  endtask

  task automatic check_wave(input string name, input int a, input int b);
    int first = -1;
    idle_until(b);
    for (int t = a; t < b; t++)
      if (first < 0 && (sd_tr[t] !== exp_sd[t] || bsy_tr[t] !== exp_bsy[t])) first = t;
    tests++;
    if (first >= 0) begin
      fails++;
      $display("FAIL %s: cycle +%0d sdwr=%b busy=%b, required sdwr=%b busy=%b",
               name, first - a, sd_tr[first], bsy_tr[first], exp_sd[first], exp_bsy[first]);
    end
  endtask

  task automatic test_reset;
    logic [7:0] d;
    rst = 1'b1; sser_n = 1'b1; ba13 = 1'b0; ba12 = 1'b1; ba = 4'h0; br_w = 1'b0; bd_in = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (sdwr !== 1'b1)    begin fails++; $display("FAIL reset_sdwr: got %b want 1", sdwr); end
    tests++; if (tx_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    tests++; if (irq !== 1'b0)     begin fails++; $display("FAIL reset_irq: got %b want 0", irq); end
    tests++; if (bd_oe !== 1'b0)   begin fails++; $display("FAIL idle_oe: got %b want 0", bd_oe); end
    bus_rd(4'h0, d);
    tests++; if (d !== 8'h01 || last_oe !== 1'b1) begin fails++; $display("FAIL reset_status: got %h oe=%b want 01 oe=1", d, last_oe); end
    bus_rd(4'h3, d);
    tests++; if (d !== 8'h00) begin fails++; $display("FAIL reset_ctrl: got %h want 00", d); end
    bus_rd(4'h5, d);
    tests++; if (d !== 8'h00 || last_oe !== 1'b1) begin fails++; $display("FAIL unmapped_read: got %h oe=%b want 00 oe=1", d, last_oe); end
    // DATA write outside the window (ba13=1) must not start a frame
    sser_n = 1'b0; ba13 = 1'b1; ba = 4'h2; br_w = 1'b0; bd_in = 8'hFF;
    @(negedge clk);
    sser_n = 1'b1; ba13 = 1'b0;
    repeat (4) @(negedge clk);
    tests++; if (tx_busy !== 1'b0) begin fails++; $display("FAIL decode_miss_busy: got %b want 0", tx_busy); end
  endtask

  task automatic test_basic;
    int n, e, cnt;
    bus_wr(4'h3, 8'h00, n);
    bus_wr(4'h2, 8'h55, n);
    clear_exp(n, n + 60);
    model_frame(n + 2, 8'h55, 1'b0, 1'b0, e);
    check_wave("frame_55", n, n + 60);
    cnt = 0;
    for (int t = n; t < n + 60; t++) if (bsy_tr[t] === 1'b1) cnt++;
    tests++; if (cnt != 40) begin fails++; $display("FAIL busy_len_55: got %0d want 40", cnt); end
  endtask

  task automatic test_parity;
    int n, e;
    logic [7:0] d;
    bus_wr(4'h3, 8'h01, n);
    bus_wr(4'h2, 8'h07, n);
    clear_exp(n, n + 60);
    model_frame(n + 2, 8'h07, 1'b1, 1'b0, e);
    check_wave("frame_07_even", n, n + 60);
    tests++; if (sd_tr[n + 2 + 9*DIV] !== 1'b1) begin fails++; $display("FAIL even_par_bit: got %b want 1", sd_tr[n + 2 + 9*DIV]); end
    bus_wr(4'h3, 8'h03, n);
    bus_rd(4'h3, d);
    tests++; if (d !== 8'h03) begin fails++; $display("FAIL ctrl_readback: got %h want 03", d); end
    bus_wr(4'h2, 8'h07, n);
    clear_exp(n, n + 60);
    model_frame(n + 2, 8'h07, 1'b1, 1'b1, e);
    check_wave("frame_07_odd", n, n + 60);
    tests++; if (sd_tr[n + 2 + 9*DIV] !== 1'b0) begin fails++; $display("FAIL odd_par_bit: got %b want 0", sd_tr[n + 2 + 9*DIV]); end
  endtask

  task automatic test_back_to_back;
    int n, m, e;
    logic [7:0] d;
    bus_wr(4'h3, 8'h00, n);
    bus_wr(4'h2, 8'hA5, n);
    bus_wr(4'h2, 8'h3C, m);
    bus_rd(4'h0, d);
    tests++; if (d !== 8'h02) begin fails++; $display("FAIL b2b_status_held: got %h want 02", d); end
    idle_until(n + 44);
    bus_rd(4'h0, d);
    tests++; if (d !== 8'h03) begin fails++; $display("FAIL b2b_status_empty: got %h want 03", d); end
    clear_exp(n, n + 95);
    model_frame(n + 2, 8'hA5, 1'b0, 1'b0, e);
    model_frame(e, 8'h3C, 1'b0, 1'b0, e);
    check_wave("b2b_frames", n, n + 95);
  endtask

  task automatic test_overrun;
    int n, m, e;
    logic [7:0] d;
    bus_wr(4'h2, 8'h11, n);
    bus_wr(4'h2, 8'h22, m);
    bus_wr(4'h2, 8'h33, m);
    bus_rd(4'h0, d);
    tests++; if (d !== 8'h06) begin fails++; $display("FAIL overrun_status: got %h want 06", d); end
    bus_rd(4'h0, d);
    tests++; if (d !== 8'h02) begin fails++; $display("FAIL overrun_cleared: got %h want 02", d); end
    clear_exp(n, n + 95);
    model_frame(n + 2, 8'h11, 1'b0, 1'b0, e);
    model_frame(e, 8'h22, 1'b0, 1'b0, e);
    check_wave("overrun_frames", n, n + 95);
  endtask

  task automatic test_held_sel;
    int n, e;
    bus_wr(4'h3, 8'h04, n);
    sser_n = 1'b0; ba13 = 1'b0; ba12 = 1'b1; ba = 4'h2; br_w = 1'b0; bd_in = 8'h81;
    n = cyc;
    repeat (6) @(negedge clk);
    sser_n = 1'b1;
    clear_exp(n, n + 60);
    model_frame(n + 2, 8'h81, 1'b0, 1'b0, e);
    check_wave("held_sel_one_frame", n, n + 60);
    tests++; if (irq_tr[n] !== 1'b1)     begin fails++; $display("FAIL irq_before: got %b want 1", irq_tr[n]); end
    tests++; if (irq_tr[n + 1] !== 1'b0) begin fails++; $display("FAIL irq_held: got %b want 0", irq_tr[n + 1]); end
    tests++; if (irq_tr[n + 2] !== 1'b1) begin fails++; $display("FAIL irq_after_xfer: got %b want 1", irq_tr[n + 2]); end
  endtask

  task automatic test_rst_mid;
    int n, m, r;
    logic [7:0] d;
    bus_wr(4'h3, 8'h00, n);
    bus_wr(4'h2, 8'hF0, n);
    bus_wr(4'h2, 8'h0F, m);
    idle_until(n + 2 + 3*DIV);
    r = cyc;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (sdwr !== 1'b1 || tx_busy !== 1'b0) begin fails++; $display("FAIL rst_mid_line: sdwr=%b busy=%b want 1/0", sdwr, tx_busy); end
    bus_rd(4'h0, d);
    tests++; if (d !== 8'h01) begin fails++; $display("FAIL rst_mid_status: got %h want 01", d); end
    clear_exp(r + 1, r + 90);
    check_wave("rst_mid_no_frame", r + 1, r + 90);
  endtask

  task automatic test_random;
    int n, m, e;
    logic [7:0] b1, b2, c;
    bit two;
    for (int k = 0; k < 8; k++) begin
      b1  = 8'($urandom);
      b2  = 8'($urandom);
      c   = 8'($urandom_range(0, 7));
      two = bit'($urandom_range(0, 1));
      bus_wr(4'h3, c, n);
      bus_wr(4'h2, b1, n);
      if (two) bus_wr(4'h2, b2, m);
      clear_exp(n, n + 110);
      model_frame(n + 2, b1, c[0], c[1], e);
      if (two) model_frame(e, b2, c[0], c[1], e);
      check_wave($sformatf("random_%0d_%h_%h_c%0d", k, b1, b2, c), n, n + 110);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_overrun();
    test_held_sel();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
